battle_turn_ctrl: RTL and testbench

BATTLE_TURN_CTRL -- requirements
Module: battle_turn_ctrl

---
 rtl/battle_turn_ctrl_pkg.sv | 42 ++++
 rtl/battle_turn_ctrl_dmg_lut.sv | 27 ++
 rtl/battle_turn_ctrl.sv | 149 ++++++++++++++
 tb/tb_battle_turn_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/battle_turn_ctrl_pkg.sv
// Shared battle definitions: attack/hit codes, damage constants, FSM states.
// Also imported by the probability machine so both sides agree on encodings.
package battle_turn_ctrl_pkg;

  localparam logic [3:0] ATK_STANDBY = 4'd0;
  localparam logic [3:0] ATK_LIGHT   = 4'd1;
  localparam logic [3:0] ATK_HEAVY   = 4'd2;

  localparam logic [1:0] HIT_NONE   = 2'd0;
  localparam logic [1:0] HIT_CRIT   = 2'd1;
  localparam logic [1:0] HIT_NORMAL = 2'd2;
  localparam logic [1:0] HIT_MISS   = 2'd3;

  localparam logic [7:0] DMG_LIGHT_NORMAL = 8'd10;
  localparam logic [7:0] DMG_LIGHT_CRIT   = 8'd20;
  localparam logic [7:0] DMG_HEAVY_NORMAL = 8'd20;
  localparam logic [7:0] DMG_HEAVY_CRIT   = 8'd40;
  localparam logic [7:0] DMG_CPU_NORMAL   = 8'd15;
  localparam logic [7:0] DMG_CPU_CRIT     = 8'd30;

  // The CPU has a single fixed attack; its type is only informational.
  localparam logic [3:0] CPU_ATK_TYPE = ATK_LIGHT;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_P_WAIT   = 3'd1,
    S_P_SETTLE = 3'd2,
    S_P_APPLY  = 3'd3,
    S_C_WAIT   = 3'd4,
    S_C_SETTLE = 3'd5,
    S_C_APPLY  = 3'd6,
    S_OVER     = 3'd7
  } state_e;

  // 9-bit subtraction so an oversized hit clamps to zero instead of wrapping.
  function automatic logic [7:0] sat_sub(input logic [7:0] hp, input logic [7:0] dmg);
    logic [8:0] diff;
    diff = {1'b0, hp} - {1'b0, dmg};
    return diff[8] ? 8'd0 : diff[7:0];
  endfunction

endpackage

// File: rtl/battle_turn_ctrl_dmg_lut.sv
// Combinational damage lookup for player (type-dependent) and CPU attacks.
module dmg_lut
  import battle_turn_ctrl_pkg::*;
(
  input  logic       is_player,
  input  logic [3:0] atk_type,
  input  logic [1:0] hit_state,
  output logic [7:0] dmg
);

  always_comb begin
    dmg = 8'd0;
    if (is_player) begin
      if (atk_type == ATK_LIGHT) begin
        if (hit_state == HIT_NORMAL)    dmg = DMG_LIGHT_NORMAL;
        else if (hit_state == HIT_CRIT) dmg = DMG_LIGHT_CRIT;
      end else if (atk_type == ATK_HEAVY) begin
        if (hit_state == HIT_NORMAL)    dmg = DMG_HEAVY_NORMAL;
        else if (hit_state == HIT_CRIT) dmg = DMG_HEAVY_CRIT;
      end
    end else begin
      if (hit_state == HIT_NORMAL)    dmg = DMG_CPU_NORMAL;
      else if (hit_state == HIT_CRIT) dmg = DMG_CPU_CRIT;
    end
  end

endmodule

// File: rtl/battle_turn_ctrl.sv
// Turn-based battle controller: alternates player and CPU attacks through an
// external probability machine and tracks both fighters' hit points.
module battle_turn_ctrl
  import battle_turn_ctrl_pkg::*;
#(
  parameter logic [7:0] INIT_HP  = 8'd100,
  parameter int         CPU_WAIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       atk_go,
  input  logic [3:0] atk_type,
  input  logic [1:0] hit_state,
  output logic [3:0] pm_type,
  output logic       pm_is_player,
  output logic [7:0] player_hp,
  output logic [7:0] cpu_hp,
  output logic [1:0] last_state,
  output logic [7:0] last_dmg,
  output logic       player_turn,
  output logic       game_over,
  output logic       player_won,
  output state_e     dbg_state_o
);

  localparam logic [7:0] WAIT_LAST = 8'(CPU_WAIT - 1);

  state_e     state_q, state_d;
  logic [7:0] player_hp_q, player_hp_d;
  logic [7:0] cpu_hp_q, cpu_hp_d;
  logic [1:0] last_state_q, last_state_d;
  logic [7:0] last_dmg_q, last_dmg_d;
  logic [3:0] type_q, type_d;
  logic [7:0] cnt_q, cnt_d;
  logic       won_q, won_d;
  logic [7:0] dmg;

  dmg_lut u_dmg_lut (
    .is_player (pm_is_player),
    .atk_type  (pm_type),
    .hit_state (hit_state),
    .dmg       (dmg)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      player_hp_q  <= 8'd0;
      cpu_hp_q     <= 8'd0;
      last_state_q <= 2'd0;
      last_dmg_q   <= 8'd0;
      type_q       <= ATK_STANDBY;
      cnt_q        <= 8'd0;
      won_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      player_hp_q  <= player_hp_d;
      cpu_hp_q     <= cpu_hp_d;
      last_state_q <= last_state_d;
      last_dmg_q   <= last_dmg_d;
      type_q       <= type_d;
      cnt_q        <= cnt_d;
      won_q        <= won_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    player_hp_d  = player_hp_q;
    cpu_hp_d     = cpu_hp_q;
    last_state_d = last_state_q;
    last_dmg_d   = last_dmg_q;
    type_d       = type_q;
    cnt_d        = cnt_q;
    won_d        = won_q;
    pm_type      = ATK_STANDBY;
    pm_is_player = 1'b0;
    case (state_q)
      // start takes priority over atk_go; a simultaneous attack is dropped
      S_IDLE, S_OVER: begin
        if (start) begin
          player_hp_d  = INIT_HP;
          cpu_hp_d     = INIT_HP;
          last_state_d = 2'd0;
          last_dmg_d   = 8'd0;
          won_d        = 1'b0;
          state_d      = S_P_WAIT;
        end
      end
      S_P_WAIT: begin
        if (atk_go && (atk_type == ATK_LIGHT || atk_type == ATK_HEAVY)) begin
          type_d  = atk_type;
          state_d = S_P_SETTLE;
        end
      end
      S_P_SETTLE: begin
        pm_type      = type_q;
        pm_is_player = 1'b1;
        state_d      = S_P_APPLY;
      end
      S_P_APPLY: begin
        pm_type      = type_q;
        pm_is_player = 1'b1;
        cpu_hp_d     = sat_sub(cpu_hp_q, dmg);
        last_state_d = hit_state;
        last_dmg_d   = dmg;
        cnt_d        = 8'd0;
        if (cpu_hp_d == 8'd0) begin
          won_d   = 1'b1;
          state_d = S_OVER;
        end else begin
          state_d = S_C_WAIT;
        end
      end
      S_C_WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = S_C_SETTLE;
        else                    cnt_d = cnt_q + 8'd1;
      end
      S_C_SETTLE: begin
        pm_type = CPU_ATK_TYPE;
        state_d = S_C_APPLY;
      end
      S_C_APPLY: begin
        pm_type      = CPU_ATK_TYPE;
        player_hp_d  = sat_sub(player_hp_q, dmg);
        last_state_d = hit_state;
        last_dmg_d   = dmg;
        if (player_hp_d == 8'd0) begin
          won_d   = 1'b0;
          state_d = S_OVER;
        end else begin
          state_d = S_P_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign player_hp   = player_hp_q;
  assign cpu_hp      = cpu_hp_q;
  assign last_state  = last_state_q;
  assign last_dmg    = last_dmg_q;
  assign player_turn = (state_q == S_P_WAIT);
  assign game_over   = (state_q == S_OVER);
  assign player_won  = won_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Directed bench for battle_turn_ctrl: a table of full rounds plus
// hand-written sequences for game over, restart and mid-battle reset.
module tb_battle_turn_ctrl;
  import battle_turn_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       atk_go = 1'b0;
  logic [3:0] atk_type = 4'd0;
  logic [1:0] hit_state = 2'd0;
  logic [3:0] pm_type;
  logic       pm_is_player;
  logic [7:0] player_hp, cpu_hp, last_dmg;
  logic [1:0] last_state;
  logic       player_turn, game_over, player_won;
  state_e     dbg_state;

  int errors = 0;
  int checks = 0;

  battle_turn_ctrl #(.INIT_HP(8'd100), .CPU_WAIT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .atk_go       (atk_go),
    .atk_type     (atk_type),
    .hit_state    (hit_state),
    .pm_type      (pm_type),
    .pm_is_player (pm_is_player),
    .player_hp    (player_hp),
    .cpu_hp       (cpu_hp),
    .last_state   (last_state),
    .last_dmg     (last_dmg),
    .player_turn  (player_turn),
    .game_over    (game_over),
    .player_won   (player_won),
    .dbg_state_o  (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ptype;
    logic [1:0] phit;
    logic [1:0] chit;
    int         exp_cpu;
    int         exp_pdmg;
    int         exp_php;
    int         exp_cdmg;
  } vec_t;

  vec_t vecs[6];

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic player_attack(input logic [3:0] ptype, input logic [1:0] phit,
                               input int exp_cpu, input int exp_dmg, input bit exp_over);
    atk_type = ptype;
    atk_go   = 1'b1;
    tick();
    atk_go   = 1'b0;
    atk_type = ATK_STANDBY;
    check("p_settle_state", dbg_state, S_P_SETTLE);
    check("p_settle_pm_type", pm_type, ptype);
    check("p_settle_is_player", pm_is_player, 1);
    hit_state = phit;
    tick();
    check("p_apply_pm_type", pm_type, ptype);
    check("p_apply_is_player", pm_is_player, 1);
    tick();
    check("p_cpu_hp", cpu_hp, exp_cpu);
    check("p_last_dmg", last_dmg, exp_dmg);
    check("p_last_state", last_state, phit);
    check("p_next_state", dbg_state, exp_over ? S_OVER : S_C_WAIT);
  endtask

  task automatic cpu_turn(input logic [1:0] chit, input int prev_php, input int exp_php,
                          input int exp_dmg, input bit exp_over, input bit inject);
    hit_state = chit;
    for (int i = 1; i <= 9; i++) begin
      if (inject && i == 3) begin
        atk_go   = 1'b1;
        atk_type = ATK_HEAVY;
      end
      tick();
      atk_go   = 1'b0;
      atk_type = ATK_STANDBY;
      check("c_is_player", pm_is_player, 0);
      if (i == 9) check("c_hp_early", player_hp, prev_php);
    end
    tick();
    check("c_player_hp", player_hp, exp_php);
    check("c_last_dmg", last_dmg, exp_dmg);
    check("c_last_state", last_state, chit);
    check("c_next_state", dbg_state, exp_over ? S_OVER : S_P_WAIT);
  endtask

  task automatic check_reset_outputs();
    check("rst_state", dbg_state, S_IDLE);
    check("rst_player_hp", player_hp, 0);
    check("rst_cpu_hp", cpu_hp, 0);
    check("rst_last_state", last_state, 0);
    check("rst_last_dmg", last_dmg, 0);
    check("rst_player_turn", player_turn, 0);
    check("rst_game_over", game_over, 0);
    check("rst_player_won", player_won, 0);
    check("rst_pm_type", pm_type, 0);
    check("rst_pm_is_player", pm_is_player, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{ATK_HEAVY, HIT_CRIT,   HIT_NORMAL, 60, 40, 85, 15};
    vecs[1] = '{ATK_LIGHT, HIT_NORMAL, HIT_CRIT,   50, 10, 55, 30};
    vecs[2] = '{ATK_HEAVY, HIT_MISS,   HIT_MISS,   50,  0, 55,  0};
    vecs[3] = '{ATK_LIGHT, HIT_NONE,   HIT_NONE,   50,  0, 55,  0};
    vecs[4] = '{ATK_HEAVY, HIT_NORMAL, HIT_NORMAL, 30, 20, 40, 15};
    vecs[5] = '{ATK_HEAVY, HIT_NORMAL, HIT_CRIT,   10, 20, 10, 30};

    repeat (3) tick();
    check_reset_outputs();
    reset = 1'b1;
    tick();
    check("idle_hold", dbg_state, S_IDLE);

    // start and atk_go together: start wins, attack dropped
    start    = 1'b1;
    atk_go   = 1'b1;
    atk_type = ATK_HEAVY;
    tick();
    start    = 1'b0;
    atk_go   = 1'b0;
    check("start_state", dbg_state, S_P_WAIT);
    check("start_player_hp", player_hp, 100);
    check("start_cpu_hp", cpu_hp, 100);
    check("start_player_turn", player_turn, 1);
    tick();
    check("start_atk_dropped", dbg_state, S_P_WAIT);

    // Invalid attack types are ignored in P_WAIT
    for (int t = 0; t < 2; t++) begin
      atk_type = (t == 0) ? ATK_STANDBY : 4'd3;
      atk_go   = 1'b1;
      tick();
      atk_go   = 1'b0;
      check("bad_type_state", dbg_state, S_P_WAIT);
      check("bad_type_cpu_hp", cpu_hp, 100);
    end

    for (int v = 0; v < 6; v++) begin
      player_attack(vecs[v].ptype, vecs[v].phit, vecs[v].exp_cpu, vecs[v].exp_pdmg, 1'b0);
      cpu_turn(vecs[v].chit, (v == 0) ? 100 : vecs[v-1].exp_php, vecs[v].exp_php,
               vecs[v].exp_cdmg, 1'b0, v == 0);
    end

    // cpu_hp 10, LIGHT CRIT: clamps to 0 and the player wins
    player_attack(ATK_LIGHT, HIT_CRIT, 0, 20, 1'b1);
    check("win_game_over", game_over, 1);
    check("win_player_won", player_won, 1);
    check("win_player_turn", player_turn, 0);
    atk_type = ATK_LIGHT;
    atk_go   = 1'b1;
    tick();
    atk_go   = 1'b0;
    tick();
    check("over_atk_ignored", dbg_state, S_OVER);
    check("over_player_hp", player_hp, 10);
    check("over_cpu_hp", cpu_hp, 0);
    check("over_pm_type", pm_type, 0);

    // Restart from OVER, then let the CPU win with a clamped final hit
    do_start();
    check("restart_state", dbg_state, S_P_WAIT);
    check("restart_player_hp", player_hp, 100);
    check("restart_cpu_hp", cpu_hp, 100);
    check("restart_last_dmg", last_dmg, 0);
    check("restart_game_over", game_over, 0);
    check("restart_player_won", player_won, 0);
    for (int k = 0; k < 4; k++) begin
      player_attack(ATK_HEAVY, HIT_MISS, 100, 0, 1'b0);
      cpu_turn(HIT_CRIT, 100 - 30 * k, (k == 3) ? 0 : 70 - 30 * k, 30, k == 3, 1'b0);
    end
    check("lose_game_over", game_over, 1);
    check("lose_player_won", player_won, 0);

    // Reset in the middle of C_WAIT
    do_start();
    player_attack(ATK_LIGHT, HIT_NORMAL, 90, 10, 1'b0);
    repeat (3) tick();
    check("pre_reset_state", dbg_state, S_C_WAIT);
    reset = 1'b0;
    tick();
    check_reset_outputs();
    reset = 1'b1;
    tick();
    check("post_reset_idle", dbg_state, S_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
